// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam logic [63:0] RF_ZERO = 64'h0;

    function automatic int unsigned rf_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: zero gating, write bypass and hold register.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              busy_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              wr_acc_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              is_zero;
    logic              hit;

    assign is_zero = (ZERO_REG != 0) && (addr_i == '0);
    assign hit     = (BYPASS != 0) && wr_acc_i
                     && (wr_addr_i == addr_i);

    always_comb begin
        data_d = mem_data_i;
        if (busy_i || is_zero) begin
            data_d = RF_ZERO[DATA_W-1:0];
        end else if (hit) begin
            data_d = wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RF_ZERO[DATA_W-1:0];
        end else if (en_i) begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with a hardware clear sequencer.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    output logic                     busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_drop,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data
);

    localparam int DEPTH = int'(rf_depth(ADDR_W));
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q;
    rf_state_e         state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic              wr_drop_q;
    logic              wr_drop_d;
    logic              wr_acc;
    logic              clearing;
    logic              zero_hit;

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign clearing = (state_q == CLEAR);
    assign zero_hit = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_acc   = wr_en && !clearing && !clr && !zero_hit;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_drop_d = wr_en && !wr_acc;
        unique case (state_q)
            CLEAR: begin
                if (clr) begin
                    ptr_d = '0;
                end else if (ptr_q == LAST) begin
                    state_d = READY;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            READY: begin
                if (clr) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            ptr_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Storage has no reset; the sequencer zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem_q[ptr_q] <= RF_ZERO[DATA_W-1:0];
        end else if (wr_acc) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign busy    = clearing;
    assign wr_drop = wr_drop_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_port (
            .clk       (clk),
            .rst       (rst),
            .en_i      (rd_en[i]),
            .busy_i    (clearing),
            .addr_i    (rd_addr[i*ADDR_W +: ADDR_W]),
            .mem_data_i(mem_q[rd_addr[i*ADDR_W +: ADDR_W]]),
            .wr_acc_i  (wr_acc),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .data_o    (rd_data[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the pipelined CPU datapath; replaces the fixed 32x32, 2-read/1-write file.
- Adds:
  - a hardware clear sequencer: after reset or on request, zeroes every entry, one per cycle;
  - per-port registered reads with hold (stall) enables;
  - optional write-to-read bypass;
  - optional hardwired-zero entry 0.
- Sits in the decode stage, written back by the writeback stage.

Parameters:
- DATA_W, 32, data width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to the read data.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous request to restart the clear sequence.
- busy  out  1  high while the clear sequence runs.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_drop  out  1  registered; pulses 1 cycle when a write with wr_en=1 was discarded.
- rd_en  in  NUM_RD  per-port read enable; 0 = hold the previous rd_data.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed registered read data; port i uses bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset (async, rst=1):
  - rd_data = 0, wr_drop = 0, busy = 1.
  - FSM state = CLEAR, clear pointer = 0.
  - Array contents are not reset directly; they are cleared by the sequencer.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle writes 0 to entry ptr, then increments ptr. On the cycle ptr = DEPTH-1 is written, go to READY; busy falls on the following edge. A full clear takes DEPTH cycles after rst deasserts, e.g. 32 cycles for ADDR_W=5.
  - READY: normal operation. clr=1 sets ptr=0 and returns to CLEAR; busy=1 from the next edge.
  - clr=1 while in CLEAR restarts the sequence at ptr=0.
- Writes:
  - Accepted in READY only, when wr_en=1.
  - A write is discarded with wr_drop=1 on the next cycle if any of these hold:
    - the FSM is in CLEAR;
    - clr=1 in the same cycle (clr wins over a simultaneous write);
    - ZERO_REG=1 and wr_addr=0.
  - wr_en=0 never raises wr_drop.
- Reads:
  - Latency 1 cycle: rd_data[i] updates on the edge where rd_en[i]=1, from the rd_addr[i] sampled at that edge.
  - rd_en[i]=0: rd_data[i] holds its value.
  - While busy=1 (FSM in CLEAR): enabled ports load 0.
  - ZERO_REG=1 and address 0: loads 0.
- Bypass:
  - Applies when BYPASS=1, the write is accepted in the same cycle, and wr_addr = rd_addr[i]. rd_data[i] then loads wr_data instead of the old contents.
  - BYPASS=0: the read returns the old contents; the new value is visible on the next read.
- All read ports are independent. Identical addresses on several ports return identical data.
- Reset asserted mid-clear or mid-operation aborts immediately; the clear restarts from entry 0 after release.

Decomposition:
- Package regfile_pkg:
  - state enum {CLEAR, READY};
  - helper function for the DEPTH computation;
  - zero constant.
- Sub-module regfile_rd_port, instantiated NUM_RD times via generate. It contains:
  - the address compare;
  - the zero-entry gating;
  - the bypass mux;
  - the hold register with async reset.
- The top holds the storage array, the FSM, the clear pointer and the write-accept/drop logic.

Test Plan:
- Reset, then release at cycle 0 → busy=1 for exactly 32 cycles. Afterwards, reads of addresses 0, 1 and 31 on both ports return 0x00000000.
- In READY: write 0xDEADBEEF to address 5, then read port0 addr 5 on the next cycle → rd_data0 = 0xDEADBEEF one cycle later.
- Bypass: in the same cycle, write 0x12345678 to address 9 and read port1 addr 9 → rd_data1 = 0x12345678 after one edge. Repeat with BYPASS=0 → rd_data1 shows the old value 0x00000000.
- Zero entry: write 0xFFFFFFFF to address 0 → wr_drop pulses 1 cycle; a subsequent read of address 0 returns 0.
- Hold: load rd_data0 = 0xA5A5A5A5 from addr 3, then set rd_en0=0 and change addr to 4 (holding 0x11) → rd_data0 stays 0xA5A5A5A5 until rd_en0=1.
- clr together with a write of 0x77 to address 7 → write dropped (wr_drop=1); busy for 32 cycles; address 7 reads 0. Then assert rst mid-clear at cycle 10 → busy stays high and the clear restarts (32 cycles after release).
